axil_reg_rd_buffered: RTL and testbench
=======================================

// Module: axil_reg_rd_buffered
// PURPOSE
//  AXI-Lite read slave to register-interface bridge, next generation of the single-shot reader.
//  Decouples AR acceptance from R backpressure via a parametrised response FIFO, honours reg_rd_wait,
//  and enforces a cycle timeout that can return SLVERR. Sits between the PS AXI-Lite port and the
//  accelerator CSR bank.
// PARAMETERS
//  DATA_WIDTH  32  data bus width (bits)
//  ADDR_WIDTH  40  address bus width (bits)
//  TIMEOUT     4   max non-wait cycles an access may wait for reg_rd_ack; >=1
//  RESP_DEPTH  4   response FIFO entries; power of 2, >=2
// PORTS
//  clk             in   1           clock
//  rst             in   1           synchronous reset, active-high
//  s_axil_araddr   in   ADDR_WIDTH  read address
//  s_axil_arprot   in   3           ignored
//  s_axil_arvalid  in   1           AR valid
//  s_axil_arready  out  1           AR ready
//  s_axil_rdata    out  DATA_WIDTH  read data (FIFO head)
//  s_axil_rresp    out  2           response code (FIFO head)
//  s_axil_rvalid   out  1           R valid
//  s_axil_rready   in   1           R ready
//  reg_rd_addr     out  ADDR_WIDTH  register address, stable while reg_rd_en=1
//  reg_rd_en       out  1           register read strobe, held until complete
//  reg_rd_data     in   DATA_WIDTH  register data, sampled on completion cycle
//  reg_rd_wait     in   1           peripheral busy: freezes timeout counter
//  reg_rd_ack      in   1           peripheral done
// BEHAVIOUR
//  Reset: arready=1, rvalid=0, rdata=0, rresp=2'b00, reg_rd_en=0, reg_rd_addr=0, FIFO empty, state IDLE.
//  AR slot: 1-entry register; arready = !ar_full (registered, no comb path from any input).
//  AR handshake (arvalid&&arready) captures araddr, sets ar_full.
//  FSM IDLE: if ar_full && fifo_count<RESP_DEPTH -> ACCESS; reg_rd_en=1, reg_rd_addr=slot, tmo=TIMEOUT-1.
//  FSM ACCESS: complete when reg_rd_ack=1 (resp OKAY) or (tmo==0 && !reg_rd_wait) (resp per macro).
//   else if !reg_rd_wait: tmo-=1; if reg_rd_wait: tmo holds. ack takes priority over timeout.
//  Completion cycle: push {reg_rd_data|err_data, resp} to FIFO; ar_full<=0; reg_rd_en<=0; -> IDLE.
//  Throughput: one access per 3 cycles min (AR accept, issue, ack); reads complete in order.
//  FIFO: rvalid = !empty; rdata/rresp = head; pop on rvalid&&rready.
//   Push+pop same cycle: count unchanged, no data loss, even when count==RESP_DEPTH-1 or full-with-pop.
//   Issue gating (count<RESP_DEPTH at issue, one access in flight) guarantees push never overflows.
//   Full FIFO: ACCESS not entered; slot stays full; arready=0 -> AR backpressured.
//  Pointers wrap modulo RESP_DEPTH; count width $clog2(RESP_DEPTH+1).
//  Reset mid-access: reg_rd_en drops next cycle, pending entry and FIFO contents discarded.
// CONFIGURATION
//  AXIL_RD_TIMEOUT_ERR_EN defined: timeout completion pushes rresp=2'b10 (SLVERR), rdata=0.
//  Undefined: timeout pushes rresp=2'b00 (OKAY), rdata=reg_rd_data as sampled (legacy behaviour).
// STRUCTURE
//  Package axil_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, rd_state_t {IDLE, ACCESS}.
//  Sub-module axil_resp_fifo (sync FIFO, width DATA_WIDTH+2, depth RESP_DEPTH, count output).
//  Top holds AR slot, FSM, timeout counter (width $clog2(TIMEOUT+1)).
// TESTING
//  1 read 0x10, ack 1 cycle after reg_rd_en, rready=1 -> rdata=reg data, rresp=00, rvalid 1 cycle.
//  2 rready=0, 5 reads acked, RESP_DEPTH=4 -> 4 entries queued, 5th AR held arready=0; drain in order.
//  3 ack never, wait=0, TIMEOUT=4 -> reg_rd_en high exactly 4 cycles; rresp=10,rdata=0 (macro on).
//  4 same as 3 without macro -> rresp=00, rdata=reg_rd_data at timeout cycle.
//  5 wait=1 for 10 cycles then ack -> no timeout, rresp=00; tmo frozen during wait.
//  6 rst asserted while reg_rd_en=1 with 2 queued -> next cycle rvalid=0, reg_rd_en=0, arready=1.

Source files
------------

// File: rtl/axil_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | axil_pkg : shared response codes and read-FSM state type for the AXI-Lite   |
// |            read bridge.                                                     |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/axil_resp_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | axil_resp_fifo : synchronous FIFO holding read responses, with occupancy    |
// |                  count; simultaneous push and pop is lossless when full.    |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module axil_resp_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             w_push, w_pop, w_full;

  assign empty  = (count_q == '0);
  assign w_full = (count_q == C_DEPTH);
  assign w_pop  = pop && !empty;
  // A full FIFO may still accept a push in the same cycle a slot is freed.
  assign w_push = push && (!w_full || w_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule
`default_nettype wire

// File: rtl/axil_reg_rd_buffered.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | axil_reg_rd_buffered : AXI-Lite read slave to register bus bridge with a    |
// |   response FIFO and wait-aware timeout. AXIL_RD_TIMEOUT_ERR_EN selects      |
// |   SLVERR/zero-data on timeout instead of OKAY with sampled data.            |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module axil_reg_rd_buffered
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 40,
  parameter int TIMEOUT    = 4,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_wait,
  input  logic                  reg_rd_ack
);

  localparam int TW = $clog2(TIMEOUT+1);
  localparam int CW = $clog2(RESP_DEPTH+1);
  localparam int FW = DATA_WIDTH + 2;
  localparam logic [TW-1:0] TMO_INIT = TW'(TIMEOUT-1);
  localparam logic [CW-1:0] C_DEPTH  = CW'(RESP_DEPTH);

  rd_state_t             state_q, state_d;
  logic                  ar_full_q, ar_full_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic                  reg_rd_en_q, reg_rd_en_d;
  logic [ADDR_WIDTH-1:0] reg_rd_addr_q, reg_rd_addr_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  logic                  w_issue, w_done, w_push, w_pop, w_empty;
  logic [FW-1:0]         w_push_data, w_head;
  logic [CW-1:0]         w_count;
  logic                  unused_arprot;

  assign unused_arprot = ^s_axil_arprot;

  assign w_issue = (state_q == IDLE) && ar_full_q && (w_count < C_DEPTH);
  // Ack wins over an expiring counter in the same cycle.
  assign w_done  = (state_q == ACCESS) &&
                   (reg_rd_ack || ((tmo_q == '0) && !reg_rd_wait));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ar_full_q     <= 1'b0;
      ar_addr_q     <= '0;
      reg_rd_en_q   <= 1'b0;
      reg_rd_addr_q <= '0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      ar_full_q     <= ar_full_d;
      ar_addr_q     <= ar_addr_d;
      reg_rd_en_q   <= reg_rd_en_d;
      reg_rd_addr_q <= reg_rd_addr_d;
      tmo_q         <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_issue) state_d = ACCESS;
      ACCESS:  if (w_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ar_full_d     = ar_full_q;
    ar_addr_d     = ar_addr_q;
    reg_rd_en_d   = reg_rd_en_q;
    reg_rd_addr_d = reg_rd_addr_q;
    tmo_d         = tmo_q;
    w_push        = 1'b0;
    if (s_axil_arvalid && !ar_full_q) begin
      ar_full_d = 1'b1;
      ar_addr_d = s_axil_araddr;
    end
    if (w_issue) begin
      reg_rd_en_d   = 1'b1;
      reg_rd_addr_d = ar_addr_q;
      tmo_d         = TMO_INIT;
    end
    if (state_q == ACCESS) begin
      if (w_done) begin
        w_push      = 1'b1;
        ar_full_d   = 1'b0;
        reg_rd_en_d = 1'b0;
      end else if (!reg_rd_wait) begin
        tmo_d = tmo_q - TW'(1);
      end
    end
  end

  always_comb begin
    if (reg_rd_ack) begin
      w_push_data = {reg_rd_data, RESP_OKAY};
    end else begin
`ifdef AXIL_RD_TIMEOUT_ERR_EN
      w_push_data = {{DATA_WIDTH{1'b0}}, RESP_SLVERR};
`else
      w_push_data = {reg_rd_data, RESP_OKAY};
`endif
    end
  end

  assign w_pop = !w_empty && s_axil_rready;

  axil_resp_fifo #(
    .WIDTH (FW),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .pop_data  (w_head),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign s_axil_arready = !ar_full_q;
  assign s_axil_rvalid  = !w_empty;
  assign s_axil_rdata   = w_empty ? '0 : w_head[FW-1:2];
  assign s_axil_rresp   = w_empty ? RESP_OKAY : w_head[1:0];
  assign reg_rd_en      = reg_rd_en_q;
  assign reg_rd_addr    = reg_rd_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_reg_rd_buffered.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_axil_reg_rd_buffered : directed bench for the buffered AXI-Lite reader.  |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_axil_reg_rd_buffered;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [39:0] reg_rd_addr;
  logic        reg_rd_en;
  logic [31:0] reg_rd_data;
  logic        reg_rd_wait;
  logic        reg_rd_ack;

  int n_err = 0;
  int n_chk = 0;
  int mode  = 0;   // 0: ack on 2nd en cycle, 1: never ack, 2: wait 10 cycles then ack

  always #5 clk = ~clk;

  axil_reg_rd_buffered #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (40),
    .TIMEOUT    (4),
    .RESP_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axil_araddr  (araddr),
    .s_axil_arprot  (arprot),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .reg_rd_addr    (reg_rd_addr),
    .reg_rd_en      (reg_rd_en),
    .reg_rd_data    (reg_rd_data),
    .reg_rd_wait    (reg_rd_wait),
    .reg_rd_ack     (reg_rd_ack)
  );

  assign reg_rd_data = 32'hA5A5_0000 | {16'h0000, reg_rd_addr[15:0]};

  initial begin : periph
    int en_cycles;
    en_cycles   = 0;
    reg_rd_ack  = 1'b0;
    reg_rd_wait = 1'b0;
    forever begin
      @(negedge clk);
      if (reg_rd_en) begin
        en_cycles++;
        case (mode)
          0: begin reg_rd_wait = 1'b0; reg_rd_ack = (en_cycles >= 2); end
          1: begin reg_rd_wait = 1'b0; reg_rd_ack = 1'b0; end
          default: begin
            reg_rd_wait = (en_cycles <= 10);
            reg_rd_ack  = (en_cycles == 11);
          end
        endcase
      end else begin
        en_cycles   = 0;
        reg_rd_ack  = 1'b0;
        reg_rd_wait = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", tag, act, exp);
    end
  endtask

  task automatic ar_send(input logic [39:0] a);
    bit hs;
    hs = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b1;
    araddr  = a;
    for (int i = 0; i < 60 && !hs; i++) begin
      @(negedge clk);
      hs = arready;
      @(posedge clk);
    end
    #1 arvalid = 1'b0;
    check("ar_handshake", 64'(hs), 64'd1);
  endtask

  // Waits for rvalid, counting reg_rd_en cycles and recording the address seen.
  task automatic expect_r(input string tag, input logic [31:0] d, input logic [1:0] r,
                          output int en_cnt, output logic [39:0] en_addr);
    bit got;
    got     = 1'b0;
    en_cnt  = 0;
    en_addr = '0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (rvalid) got = 1'b1;
      else if (reg_rd_en) begin
        en_cnt++;
        en_addr = reg_rd_addr;
      end
    end
    check({tag, "_rvalid"}, 64'(got), 64'd1);
    if (got) begin
      check({tag, "_rdata"}, 64'(rdata), 64'(d));
      check({tag, "_rresp"}, 64'(rresp), 64'(r));
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          n;
    logic [39:0] a;
    bit          seen;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;

    rst     = 1'b1;
    araddr  = '0;
    arprot  = 3'b000;
    arvalid = 1'b0;
    rready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_arready", 64'(arready), 64'd1);
    check("rst_rvalid",  64'(rvalid),  64'd0);
    check("rst_rdata",   64'(rdata),   64'd0);
    check("rst_rresp",   64'(rresp),   64'd0);
    check("rst_en",      64'(reg_rd_en), 64'd0);
    check("rst_addr",    64'(reg_rd_addr), 64'd0);
    rst = 1'b0;

    // Single read, ack on the cycle after reg_rd_en rises.
    mode   = 0;
    rready = 1'b1;
    ar_send(40'h10);
    expect_r("t1", 32'hA5A5_0010, 2'b00, n, a);
    check("t1_en_cycles", 64'(n), 64'd2);
    check("t1_addr", 64'(a), 64'h10);
    @(negedge clk);
    check("t1_rvalid_one_cycle", 64'(rvalid), 64'd0);

    // Backpressure: four responses fill the FIFO, the fifth sits in the slot.
    @(posedge clk); #1;
    rready = 1'b0;
    for (int k = 0; k < 5; k++) ar_send(40'h100 + 40'(4 * k));
    repeat (10) @(negedge clk);
    check("t2_arready_held", 64'(arready), 64'd0);
    check("t2_no_issue",     64'(reg_rd_en), 64'd0);
    check("t2_head_valid",   64'(rvalid),  64'd1);
    check("t2_head_data",    64'(rdata),   64'hA5A5_0100);
    @(posedge clk); #1;
    rready = 1'b1;
    expect_r("t2_0", 32'hA5A5_0100, 2'b00, n, a);
    expect_r("t2_1", 32'hA5A5_0104, 2'b00, n, a);
    expect_r("t2_2", 32'hA5A5_0108, 2'b00, n, a);
    expect_r("t2_3", 32'hA5A5_010C, 2'b00, n, a);
    expect_r("t2_4", 32'hA5A5_0110, 2'b00, n, a);
    @(negedge clk);
    check("t2_drained", 64'(rvalid), 64'd0);

    // Timeout with no ack and no wait.
    mode = 1;
`ifdef AXIL_RD_TIMEOUT_ERR_EN
    exp_d = 32'h0000_0000;
    exp_r = 2'b10;
`else
    exp_d = 32'hA5A5_0020;
    exp_r = 2'b00;
`endif
    ar_send(40'h20);
    expect_r("t3", exp_d, exp_r, n, a);
    check("t3_en_cycles", 64'(n), 64'd4);
    check("t3_addr", 64'(a), 64'h20);

    // Long wait freezes the timeout; ack arrives on the 11th en cycle.
    mode = 2;
    ar_send(40'h30);
    expect_r("t5", 32'hA5A5_0030, 2'b00, n, a);
    check("t5_en_cycles", 64'(n), 64'd11);

    // Reset while an access is in flight with two responses queued.
    @(posedge clk); #1;
    rready = 1'b0;
    mode   = 0;
    ar_send(40'h40);
    ar_send(40'h44);
    repeat (8) @(negedge clk);
    check("t6_queued", 64'(rvalid), 64'd1);
    mode = 1;
    ar_send(40'h48);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = reg_rd_en;
    end
    check("t6_en_seen", 64'(seen), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rvalid",  64'(rvalid),    64'd0);
    check("t6_en",      64'(reg_rd_en), 64'd0);
    check("t6_arready", 64'(arready),   64'd1);
    check("t6_rdata",   64'(rdata),     64'd0);
    rst    = 1'b0;
    mode   = 0;
    rready = 1'b1;
    ar_send(40'h50);
    expect_r("t6_post", 32'hA5A5_0050, 2'b00, n, a);
    @(negedge clk);
    check("t6_post_empty", 64'(rvalid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
